fetch_pcctl: RTL and testbench

- Fetch-stage PC sequencer for the 64-bit RISC-V pipeline.
- Owns the architectural fetch PC and drives the instruction bus request.
- Feeds each returned instruction through a predictpc instance to choose the next PC, and hands {pc, instr, predpc} to decode with a valid/ready handshake.
- Absorbs execute-stage redirects (mispredict, JALR target), including redirects that arrive while a bus request is in flight.

---
 rtl/fetch_pcctl_pkg.sv | 29 ++
 rtl/fetch_pcctl_predictpc.sv | 27 ++
 rtl/fetch_pcctl.sv | 131 +++++++++++++
 tb/tb_fetch_pcctl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pcctl_pkg.sv
// Shared fetch-pipe types and RISC-V opcode constants used by the PC sequencer.
package fetch_pcctl_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned OPW  = 7;

  localparam logic [OPW-1:0] OP_B    = 7'b1100011;
  localparam logic [OPW-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OPW-1:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    JWAIT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] predpc;
  } fetch_data_t;

  function automatic logic [OPW-1:0] opcode_of(input logic [ILEN-1:0] instr);
    return instr[OPW-1:0];
  endfunction

endpackage

// File: rtl/fetch_pcctl_predictpc.sv
// Static next-PC predictor: branches predicted taken, JAL followed, JALR unknown (0).
module fetch_pcctl_predictpc
  import fetch_pcctl_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] predpc_c
);

  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;

  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Plain modulo-2^64 adds; wrap-around and misaligned targets pass through
  always_comb begin
    predpc_c = pc + XLEN'(4);
    unique case (opcode_of(instr))
      OP_B:    predpc_c = pc + imm_b;
      OP_JAL:  predpc_c = pc + imm_j;
      OP_JALR: predpc_c = '0;
      default: predpc_c = pc + XLEN'(4);
    endcase
  end

endmodule

// File: rtl/fetch_pcctl.sv
// Fetch-stage PC sequencer: issues instruction bus requests, predicts the next PC,
// presents fetched instructions to decode and absorbs execute-stage redirects.
module fetch_pcctl
  import fetch_pcctl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            f_valid,
  input  logic            f_ready,
  output logic [XLEN-1:0] f_pc,
  output logic [ILEN-1:0] f_instr,
  output logic [XLEN-1:0] f_predpc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] predpc_q, predpc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            ireq_valid_q, ireq_valid_d;
  logic            f_valid_q, f_valid_d;
  logic [XLEN-1:0] pred_c;
  fetch_data_t     f_data;

  fetch_pcctl_predictpc u_predictpc (
    .pc       (pc_q),
    .instr    (iresp_data),
    .predpc_c (pred_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      predpc_q     <= '0;
      req_addr_q   <= RESET_PC;
      ireq_valid_q <= 1'b0;
      f_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      predpc_q     <= predpc_d;
      req_addr_q   <= req_addr_d;
      ireq_valid_q <= ireq_valid_d;
      f_valid_q    <= f_valid_d;
    end
  end

  // Next-state logic; a redirect overrides every other event in every state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    predpc_d  = predpc_q;
    f_valid_d = f_valid_q;

    unique case (state_q)
      REQ: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          f_valid_d = 1'b0;
          state_d   = iresp_data_ok ? REQ : DRAIN;
        end else if (iresp_data_ok) begin
          instr_d   = iresp_data;
          predpc_d  = pred_c;
          f_valid_d = 1'b1;
          state_d   = (opcode_of(iresp_data) == OP_JALR) ? JWAIT : HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          f_valid_d = 1'b0;
          state_d   = REQ;
        end else if (f_ready) begin
          pc_d      = predpc_q;
          f_valid_d = 1'b0;
          state_d   = REQ;
        end
      end
      DRAIN: begin
        f_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (iresp_data_ok) begin
          state_d = REQ;
        end
      end
      JWAIT: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          f_valid_d = 1'b0;
          state_d   = REQ;
        end else if (f_ready) begin
          f_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = REQ;
        f_valid_d = 1'b0;
      end
    endcase
  end

  // The bus address only moves when a fresh request starts; DRAIN keeps the old one
  always_comb begin
    ireq_valid_d = (state_d == REQ) || (state_d == DRAIN);
    req_addr_d   = (state_d == REQ) ? pc_d : req_addr_q;
  end

  assign f_data = '{pc: pc_q, instr: instr_q, predpc: predpc_q};

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = req_addr_q;
  assign f_valid    = f_valid_q & ~redirect_valid;
  assign f_pc       = f_data.pc;
  assign f_instr    = f_data.instr;
  assign f_predpc   = f_data.predpc;

endmodule

// File: tb/tb_fetch_pcctl.sv
// Directed bench for fetch_pcctl: cycle-level reference model plus literal spot checks.
module tb_fetch_pcctl;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] I_ADDI  = 32'h0010_0093;
  localparam logic [31:0] I_BEQ_M8 = 32'hFE00_0CE3;
  localparam logic [31:0] I_BEQ_P16 = 32'h0000_0863;
  localparam logic [31:0] I_JALR  = 32'h0000_8067;
  localparam logic [31:0] I_JAL_P8 = 32'h0080_006F;

  localparam int M_FETCH   = 0;
  localparam int M_SHOW    = 1;
  localparam int M_DISCARD = 2;
  localparam int M_JWAIT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        f_valid;
  logic        f_ready;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic [63:0] f_predpc;

  int errors = 0;
  int checks = 0;

  fetch_pcctl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_valid        (f_valid),
    .f_ready        (f_ready),
    .f_pc           (f_pc),
    .f_instr        (f_instr),
    .f_predpc       (f_predpc)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_mode;
  logic        m_live;
  logic        m_show;
  logic [63:0] m_pc;
  logic [63:0] m_req_addr;
  logic [31:0] m_instr;
  logic [63:0] m_pred;

  logic        e_ireq_valid;
  logic [63:0] e_ireq_addr;
  logic        e_show;
  logic        e_f_valid;
  logic [63:0] e_f_pc;
  logic [31:0] e_f_instr;
  logic [63:0] e_f_predpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC from the instruction's meaning, using signed integer arithmetic
  function automatic logic [63:0] predict(input logic [63:0] pc, input logic [31:0] ins);
    longint off;
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'b1100111) return 64'd0;
    if (op == 7'b1100011) begin
      off = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      return pc + 64'(off);
    end
    if (op == 7'b1101111) begin
      off = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      return pc + 64'(off);
    end
    return pc + 64'd4;
  endfunction

  task automatic model_reset();
    m_mode = M_FETCH; m_live = 1'b0; m_show = 1'b0;
    m_pc = RST_PC; m_req_addr = RST_PC; m_instr = '0; m_pred = '0;
  endtask

  task automatic set_exp();
    e_ireq_valid = m_live;
    e_ireq_addr  = m_req_addr;
    e_show       = m_show;
    e_f_valid    = m_show && !redirect_valid;
    e_f_pc       = m_pc;
    e_f_instr    = m_instr;
    e_f_predpc   = m_pred;
  endtask

  // Applies one clock edge worth of fetch-stage rules to the model
  task automatic model_edge();
    if (redirect_valid) begin
      m_pc = redirect_pc;
      m_show = 1'b0;
      if (m_mode == M_FETCH && !iresp_data_ok) m_mode = M_DISCARD;
      else if (m_mode == M_DISCARD && !iresp_data_ok) m_mode = M_DISCARD;
      else m_mode = M_FETCH;
    end else if (m_mode == M_FETCH && iresp_data_ok) begin
      m_instr = iresp_data;
      m_pred = predict(m_pc, iresp_data);
      m_show = 1'b1;
      m_mode = (iresp_data[6:0] == 7'b1100111) ? M_JWAIT : M_SHOW;
    end else if (m_mode == M_SHOW && f_ready) begin
      m_pc = m_pred;
      m_show = 1'b0;
      m_mode = M_FETCH;
    end else if (m_mode == M_DISCARD && iresp_data_ok) begin
      m_mode = M_FETCH;
    end else if (m_mode == M_JWAIT && f_ready) begin
      m_show = 1'b0;
    end
    if (m_mode == M_FETCH) m_req_addr = m_pc;
    m_live = (m_mode == M_FETCH) || (m_mode == M_DISCARD);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("ireq_valid", 64'(ireq_valid), 64'(e_ireq_valid));
    if (e_ireq_valid) chk("ireq_addr", ireq_addr, e_ireq_addr);
    chk("f_valid", 64'(f_valid), 64'(e_f_valid));
    if (e_show) begin
      chk("f_pc", f_pc, e_f_pc);
      chk("f_instr", 64'(f_instr), 64'(e_f_instr));
      chk("f_predpc", f_predpc, e_f_predpc);
    end
  end

  task automatic drive_set(input logic dok, input logic [31:0] data, input logic rv,
                           input logic [63:0] rpc, input logic rdy);
    iresp_data_ok = dok; iresp_data = data;
    redirect_valid = rv; redirect_pc = rpc; f_ready = rdy;
    set_exp();
  endtask

  task automatic drive_edge();
    @(posedge clk);
    model_edge();
    #1;
    iresp_data_ok = 1'b0;
    redirect_valid = 1'b0;
    set_exp();
  endtask

  task automatic drive(input logic dok, input logic [31:0] data, input logic rv,
                       input logic [63:0] rpc, input logic rdy);
    drive_set(dok, data, rv, rpc, rdy);
    drive_edge();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    iresp_data_ok = 1'b0; iresp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; f_ready = 1'b0;
    model_reset();
    set_exp();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_valid", 64'(f_valid), 64'd0);
    chk("rst_f_pc", f_pc, RST_PC);
    chk("rst_f_instr", 64'(f_instr), 64'd0);
    chk("rst_f_predpc", f_predpc, 64'd0);
    reset = 1'b1;

    // Sequential code
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("first_req_valid", 64'(ireq_valid), 64'd1);
    chk("first_req_addr", ireq_addr, 64'h8000_0000);
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b0);
    chk("seq_f_valid", 64'(f_valid), 64'd1);
    chk("seq_f_pc", f_pc, 64'h8000_0000);
    chk("seq_f_predpc", f_predpc, 64'h8000_0004);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("seq_next_addr", ireq_addr, 64'h8000_0004);

    // Forward branch
    drive(1'b1, I_BEQ_P16, 1'b0, '0, 1'b0);
    chk("fwd_br_predpc", f_predpc, 64'h8000_0014);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("fwd_br_next_addr", ireq_addr, 64'h8000_0014);

    // Decode stall for 5 cycles
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b0);
    repeat (5) drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("stall_no_req", 64'(ireq_valid), 64'd0);
    chk("stall_f_pc", f_pc, 64'h8000_0014);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("stall_release_addr", ireq_addr, 64'h8000_0018);
    chk("stall_release_valid", 64'(ireq_valid), 64'd1);

    // Redirect in HOLD with f_ready high: instruction dropped
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b0);
    drive_set(1'b0, '0, 1'b1, 64'h8000_0010, 1'b1);
    #1;
    chk("hold_redirect_mask", 64'(f_valid), 64'd0);
    drive_edge();
    chk("hold_redirect_addr", ireq_addr, 64'h8000_0010);

    // Backward branch
    drive(1'b1, I_BEQ_M8, 1'b0, '0, 1'b0);
    chk("bwd_br_f_pc", f_pc, 64'h8000_0010);
    chk("bwd_br_predpc", f_predpc, 64'h8000_0008);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("bwd_br_next_addr", ireq_addr, 64'h8000_0008);

    // Redirect while a request is in flight
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 64'h8000_0004, 1'b0);
    chk("req_at_0004", ireq_addr, 64'h8000_0004);
    drive(1'b0, '0, 1'b1, 64'h8000_0100, 1'b0);
    chk("drain_addr_frozen", ireq_addr, 64'h8000_0004);
    repeat (2) drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("drain_still_frozen", ireq_addr, 64'h8000_0004);
    chk("drain_no_f_valid", 64'(f_valid), 64'd0);
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b1);
    chk("drain_done_addr", ireq_addr, 64'h8000_0100);
    chk("drain_data_dropped", 64'(f_valid), 64'd0);

    // Redirect coinciding with data_ok: data dropped, refetch
    drive(1'b1, I_ADDI, 1'b1, 64'h8000_0020, 1'b0);
    chk("same_cycle_addr", ireq_addr, 64'h8000_0020);
    chk("same_cycle_f_valid", 64'(f_valid), 64'd0);

    // JALR stall
    drive(1'b1, I_JALR, 1'b0, '0, 1'b0);
    chk("jalr_f_valid", 64'(f_valid), 64'd1);
    chk("jalr_f_pc", f_pc, 64'h8000_0020);
    chk("jalr_predpc", f_predpc, 64'd0);
    chk("jalr_no_req", 64'(ireq_valid), 64'd0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("jalr_taken_f_valid", 64'(f_valid), 64'd0);
    repeat (2) drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("jalr_wait_no_req", 64'(ireq_valid), 64'd0);
    drive(1'b0, '0, 1'b1, 64'h8000_0300, 1'b0);
    chk("jalr_redirect_addr", ireq_addr, 64'h8000_0300);
    chk("jalr_redirect_valid", 64'(ireq_valid), 64'd1);

    // JAL
    drive(1'b1, I_JAL_P8, 1'b0, '0, 1'b0);
    chk("jal_predpc", f_predpc, 64'h8000_0308);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("jal_next_addr", ireq_addr, 64'h8000_0308);

    // Double redirect in DRAIN, then 64-bit wrap-around
    drive(1'b0, '0, 1'b1, 64'h0000_0000_0000_1234, 1'b0);
    drive(1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    chk("drain2_frozen", ireq_addr, 64'h8000_0308);
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b0);
    chk("drain2_last_wins", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b0);
    chk("wrap_predpc", f_predpc, 64'd0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("wrap_next_addr", ireq_addr, 64'd0);

    // Asynchronous reset while in DRAIN
    drive(1'b0, '0, 1'b1, 64'h8000_0040, 1'b0);
    chk("pre_reset_frozen", ireq_addr, 64'd0);
    #2;
    reset = 1'b0;
    model_reset();
    set_exp();
    #1;
    chk("async_rst_f_valid", 64'(f_valid), 64'd0);
    chk("async_rst_f_pc", f_pc, RST_PC);
    chk("async_rst_ireq_valid", 64'(ireq_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    set_exp();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("post_rst_addr", ireq_addr, 64'h8000_0000);
    chk("post_rst_valid", 64'(ireq_valid), 64'd1);
    drive(1'b1, I_ADDI, 1'b0, '0, 1'b0);
    chk("post_rst_f_pc", f_pc, 64'h8000_0000);
    chk("post_rst_predpc", f_predpc, 64'h8000_0004);
    drive(1'b0, '0, 1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
